// File: rtl/brief_desc_pack.sv
// Packs a serial stream of comparator bits into one DESC_BITS-wide descriptor per keypoint.
// The finished descriptor is held with its coordinates until the downstream side accepts it.
module brief_desc_pack #(
  parameter int DESC_BITS   = 256,
  parameter int COORD_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   kp_start,
  input  logic [COORD_WIDTH-1:0] kp_x,
  input  logic [COORD_WIDTH-1:0] kp_y,
  input  logic                   cmp_bit,
  input  logic                   cmp_valid,
  input  logic                   desc_ready,
  input  logic                   ovf_clr,
  output logic                   desc_valid,
  output logic [DESC_BITS-1:0]   desc_out,
  output logic [COORD_WIDTH-1:0] desc_x,
  output logic [COORD_WIDTH-1:0] desc_y,
  output logic                   busy,
  output logic                   overflow,
  output logic                   stray
);

  localparam int CNT_W = $clog2(DESC_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DESC_BITS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       bit_cnt_reg, bit_cnt_next;
  logic [DESC_BITS-1:0]   desc_bits_reg, desc_bits_next;
  logic [DESC_BITS-1:0]   wr_en;
  logic [COORD_WIDTH-1:0] x_reg, y_reg;
  logic                   overflow_reg, stray_reg;
  logic                   open_desc;
  logic                   take_bit;
  logic                   set_ovf;
  logic                   set_stray;

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    open_desc    = 1'b0;
    take_bit     = 1'b0;
    set_ovf      = 1'b0;
    set_stray    = 1'b0;
    case (state_reg)
      IDLE: begin
        // A bit arriving with no open descriptor is lost, even alongside kp_start.
        if (cmp_valid) set_stray = 1'b1;
        if (kp_start) begin
          open_desc  = 1'b1;
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (kp_start) begin
          open_desc = 1'b1;
          set_stray = 1'b1;
        end else if (cmp_valid) begin
          take_bit = 1'b1;
          if (bit_cnt_reg == LAST_BIT) begin
            state_next   = HOLD;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (desc_ready) begin
          if (kp_start) begin
            open_desc  = 1'b1;
            state_next = COLLECT;
          end else begin
            state_next = IDLE;
          end
        end else if (cmp_valid || kp_start) begin
          set_ovf = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (open_desc) bit_cnt_next = '0;
  end

  // One write-enable per descriptor bit, decoded from the arrival counter.
  generate
    for (genvar gi = 0; gi < DESC_BITS; gi++) begin : g_bit
      assign wr_en[gi] = take_bit && (bit_cnt_reg == CNT_W'(gi));
      assign desc_bits_next[gi] = open_desc ? 1'b0 :
                                  (wr_en[gi] ? cmp_bit : desc_bits_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      desc_bits_reg <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
      overflow_reg  <= 1'b0;
      stray_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      desc_bits_reg <= desc_bits_next;
      if (open_desc) begin
        x_reg <= kp_x;
        y_reg <= kp_y;
      end
      // A new error in the same cycle as the clear wins.
      overflow_reg <= set_ovf   | (overflow_reg & ~ovf_clr);
      stray_reg    <= set_stray | (stray_reg    & ~ovf_clr);
    end
  end

  assign desc_valid = (state_reg == HOLD);
  assign busy       = (state_reg != IDLE);
  assign desc_out   = desc_bits_reg;
  assign desc_x     = x_reg;
  assign desc_y     = y_reg;
  assign overflow   = overflow_reg;
  assign stray      = stray_reg;

endmodule
